// File: rtl/spmv_mem_arbiter.sv
// Memory-request arbiter and y-vector store sequencer for one SpMV PE.
// Define SPMV_ARB_STATS_EN to build the grant/stall statistics counters.
module spmv_mem_arbiter #(
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             st_base_ld,
  input  logic [47:0]      st_base,
  input  logic             st_end_ld,
  input  logic [47:0]      st_end,
  input  logic             st_empty,
  input  logic [63:0]      st_q,
  output logic             st_pop,
  input  logic             ca_empty,
  input  logic [47:0]      ca_q,
  output logic             ca_pop,
  input  logic             de_empty,
  input  logic [49:0]      de_q,
  output logic             de_pop,
  output logic             req_mem_ld,
  output logic             req_mem_st,
  output logic [47:0]      req_mem_addr,
  output logic [63:0]      req_mem_d_or_tag,
  input  logic             req_mem_stall,
  output logic             st_done,
  output logic [CNT_W-1:0] stat_grants_st,
  output logic [CNT_W-1:0] stat_grants_ca,
  output logic [CNT_W-1:0] stat_grants_de,
  output logic [CNT_W-1:0] stat_stall_cycles
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {SRC_NONE, SRC_ST, SRC_CA, SRC_DE} src_t;

  src_t          grant;
  src_t          s1_src;
  logic          can_pop;
  logic [SW-1:0] ca_starve;
  logic [SW-1:0] de_starve;
  logic [47:0]   st_ptr;
  logic [47:0]   st_end_r;

  assign can_pop = !rst && enable && !req_mem_stall;

  // Starvation overrides sit above the fixed st > ca > de order; de wins a tie.
  always_comb begin
    grant = SRC_NONE;
    if (can_pop) begin
      if (de_starve == LIM && !de_empty)      grant = SRC_DE;
      else if (ca_starve == LIM && !ca_empty) grant = SRC_CA;
      else if (!st_empty)                     grant = SRC_ST;
      else if (!ca_empty)                     grant = SRC_CA;
      else if (!de_empty)                     grant = SRC_DE;
    end
  end

  assign st_pop  = (grant == SRC_ST);
  assign ca_pop  = (grant == SRC_CA);
  assign de_pop  = (grant == SRC_DE);
  assign st_done = (st_ptr == st_end_r);

  function automatic logic [SW-1:0] next_starve(input logic [SW-1:0] cur, input logic empty,
                                                input logic mine, input logic any);
    if (empty || mine)          return '0;
    else if (any && cur != LIM) return cur + SW'(1);
    else                        return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_src           <= SRC_NONE;
      ca_starve        <= '0;
      de_starve        <= '0;
      st_ptr           <= '0;
      st_end_r         <= '0;
      req_mem_ld       <= 1'b0;
      req_mem_st       <= 1'b0;
      req_mem_addr     <= '0;
      req_mem_d_or_tag <= '0;
    end else begin
      s1_src    <= grant;
      ca_starve <= next_starve(ca_starve, ca_empty, grant == SRC_CA, grant != SRC_NONE);
      de_starve <= next_starve(de_starve, de_empty, grant == SRC_DE, grant != SRC_NONE);

      req_mem_ld <= 1'b0;
      req_mem_st <= 1'b0;
      // FIFO q is valid now, one cycle after the pop recorded in s1_src.
      if (enable) begin
        case (s1_src)
          SRC_ST: if (!st_done) begin
            req_mem_st       <= 1'b1;
            req_mem_addr     <= st_ptr;
            req_mem_d_or_tag <= st_q;
            st_ptr           <= st_ptr + 48'd8;
          end
          SRC_CA: begin
            req_mem_ld       <= 1'b1;
            req_mem_addr     <= ca_q;
            req_mem_d_or_tag <= 64'h1;
          end
          SRC_DE: begin
            req_mem_ld       <= 1'b1;
            req_mem_addr     <= de_q[49:2];
            req_mem_d_or_tag <= {61'b0, de_q[1:0], 1'b0};
          end
          default: ;
        endcase
      end

      if (st_base_ld) st_ptr   <= st_base;
      if (st_end_ld)  st_end_r <= st_end;
    end
  end

`ifdef SPMV_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_st, cnt_ca, cnt_de, cnt_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_st    <= '0;
      cnt_ca    <= '0;
      cnt_de    <= '0;
      cnt_stall <= '0;
    end else begin
      if (st_pop) cnt_st <= cnt_st + CNT_W'(1);
      if (ca_pop) cnt_ca <= cnt_ca + CNT_W'(1);
      if (de_pop) cnt_de <= cnt_de + CNT_W'(1);
      if (req_mem_stall && (!st_empty || !ca_empty || !de_empty))
        cnt_stall <= cnt_stall + CNT_W'(1);
    end
  end

  assign stat_grants_st    = cnt_st;
  assign stat_grants_ca    = cnt_ca;
  assign stat_grants_de    = cnt_de;
  assign stat_stall_cycles = cnt_stall;
`else
  assign stat_grants_st    = '0;
  assign stat_grants_ca    = '0;
  assign stat_grants_de    = '0;
  assign stat_stall_cycles = '0;
`endif

endmodule
